frame_buffer: RTL



---
 rtl/mel_pkg.sv | 17 +
 rtl/frame_ram.sv | 25 ++
 rtl/frame_buffer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mel_pkg.sv
// Shared types and constants for the mel front-end blocks.
package mel_pkg;

   typedef logic signed [15:0] sample_t;

   typedef enum logic [1:0] {FILL, WAIT, READ} fb_state_t;

   localparam int PREEMPH_COEF = 31785;

   function automatic sample_t sat17(input logic signed [16:0] v);
      if (v[16] != v[15]) begin
         return v[16] ? 16'sh8000 : 16'sh7FFF;
      end
      return sample_t'(v[15:0]);
   endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port N x 16 sample RAM, read-first, one registered read port.
module frame_ram
   import mel_pkg::*;
#(
   parameter int N  = 512,
   parameter int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  sample_t       i_wr_data,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_rd_addr,
   output sample_t       o_rd_data
);

   sample_t r_mem [N];

   // Same-address read and write return the old word.
   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
   end

endmodule

// File: rtl/frame_buffer.sv
// Overlapping-frame generator: circular sample store bursting the last N samples every HOP.
// Optional write-path pre-emphasis enabled by defining FRAME_BUFFER_PREEMPH_EN.
module frame_buffer
   import mel_pkg::*;
#(
   parameter int N   = 512,
   parameter int HOP = 256
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [15:0] sample_in,
   input  logic               sample_valid,
   output logic signed [15:0] frame_out,
   output logic               frame_valid,
   output logic               frame_first,
   output logic               frame_last,
   output logic               overrun
);

   localparam int AW = $clog2(N);
   localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
   localparam logic [AW-1:0] HOP_LAST = AW'(HOP - 1);

   fb_state_t     r_state, w_state_nxt;
   logic [AW-1:0] r_wr_ptr, r_rd_ptr, r_cnt, r_rd_cnt;
   logic          r_rd_pend, r_rd_first, r_rd_last;
   logic          w_trig, w_rd_done, w_rd_en, w_start, w_ovr_set;
   sample_t       w_wr_data, w_ram_q;

`ifdef FRAME_BUFFER_PREEMPH_EN
   sample_t            r_prev;
   logic signed [31:0] w_prod;
   logic signed [16:0] w_diff;

   assign w_prod    = r_prev * sample_t'(PREEMPH_COEF);
   assign w_diff    = $signed({sample_in[15], sample_in}) - 17'(w_prod >>> 15);
   assign w_wr_data = sat17(w_diff);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)             r_prev <= '0;
      else if (sample_valid) r_prev <= sample_in;
   end
`else
   assign w_wr_data = sample_in;
`endif

   assign w_trig    = sample_valid && (r_cnt == ((r_state == FILL) ? LAST_IDX : HOP_LAST));
   assign w_rd_en   = (r_state == READ);
   assign w_rd_done = w_rd_en && (r_rd_cnt == LAST_IDX);

   // A trigger landing on the final read chains straight into the next burst.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_ovr_set   = 1'b0;
      unique case (r_state)
         FILL, WAIT: begin
            if (w_trig) begin
               w_state_nxt = READ;
               w_start     = 1'b1;
            end
         end
         READ: begin
            if (w_rd_done) begin
               w_state_nxt = w_trig ? READ : WAIT;
               w_start     = w_trig;
            end else if (w_trig) begin
               w_ovr_set = 1'b1;
            end
         end
         default: w_state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= FILL;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_cnt       <= '0;
         r_rd_cnt    <= '0;
         r_rd_pend   <= 1'b0;
         r_rd_first  <= 1'b0;
         r_rd_last   <= 1'b0;
         frame_out   <= '0;
         frame_valid <= 1'b0;
         frame_first <= 1'b0;
         frame_last  <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (sample_valid) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_cnt    <= w_trig ? '0 : r_cnt + AW'(1);
         end
         if (w_start) begin
            r_rd_ptr <= r_wr_ptr + AW'(1);
            r_rd_cnt <= '0;
         end else if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            r_rd_cnt <= r_rd_cnt + AW'(1);
         end
         r_rd_pend   <= w_rd_en;
         r_rd_first  <= w_rd_en && (r_rd_cnt == '0);
         r_rd_last   <= w_rd_done;
         frame_valid <= r_rd_pend;
         frame_first <= r_rd_first;
         frame_last  <= r_rd_last;
         if (r_rd_pend) frame_out <= w_ram_q;
         if (w_ovr_set) overrun <= 1'b1;
      end
   end

   frame_ram #(.N(N)) u_ram (
      .clk       (clk),
      .i_wr_en   (sample_valid),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (w_wr_data),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_ram_q)
   );

endmodule
